// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 controller user interface and its host traffic generator.
package ddr3_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FILL_W = 6;
    localparam int unsigned IDX_W  = 10;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned ITMO_W = 20;
    localparam int unsigned DTMO_W = 12;

    typedef enum logic [2:0] {
        CMD_NOP = 3'b000,
        CMD_SCR = 3'b001,
        CMD_SCW = 3'b010
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } tg_state_t;

    // Test pattern: low address bits keyed by the seed
    function automatic logic [DATA_W-1:0] expected_data(input logic [ADDR_W-1:0] a,
                                                        input logic [DATA_W-1:0] seed);
        return a[DATA_W-1:0] ^ seed;
    endfunction

endpackage

// File: rtl/ddr3_tg_checker.sv
// Return-path checker: validates popped words, counts returns and errors, and
// watches for a stalled drain.
module ddr3_tg_checker
    import ddr3_pkg::*;
#(
    parameter int unsigned        NUM_WORDS     = 16,
    parameter logic [ADDR_W-1:0]  BASE_ADDR     = 25'h0000000,
    parameter logic [DATA_W-1:0]  SEED          = 16'hACE1,
    parameter logic [DTMO_W-1:0]  DRAIN_TIMEOUT = 12'hFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_pop,
    input  logic              i_drain,
    input  logic              i_init_tmo,
    input  logic [DATA_W-1:0] i_dout,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              o_all_returned_c,
    output logic              o_drain_tmo_c,
    output logic [ERR_W-1:0]  o_err_count
);

    logic [CNT_W-1:0]  r_ret_cnt;
    logic [DTMO_W-1:0] r_idle;
    logic [ERR_W-1:0]  r_err;

    logic [ADDR_W-1:0] w_offset;
    logic              w_in_range;
    logic              w_mismatch;
    logic              w_bad_pop;
    logic [CNT_W-1:0]  w_ret_next;
    logic              w_add_err;

    // Offset arithmetic wraps modulo 2^25, so the range check follows the address wrap
    assign w_offset   = i_raddr - BASE_ADDR;
    assign w_in_range = (w_offset < ADDR_W'(NUM_WORDS));
    assign w_mismatch = (i_dout != expected_data(i_raddr, SEED));
    assign w_bad_pop  = i_pop && (w_mismatch || !w_in_range);
    assign w_ret_next = r_ret_cnt + CNT_W'(i_pop);

    // Includes the pop in flight so DONE follows the last pop by one cycle
    assign o_all_returned_c = (w_ret_next >= CNT_W'(NUM_WORDS));
    assign o_drain_tmo_c    = i_drain && !i_pop && !o_all_returned_c &&
                              (r_idle == (DRAIN_TIMEOUT - DTMO_W'(1)));
    assign w_add_err        = w_bad_pop || o_drain_tmo_c;
    assign o_err_count      = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ret_cnt <= '0;
            r_idle    <= '0;
            r_err     <= '0;
        end else if (i_clear) begin
            r_ret_cnt <= '0;
            r_idle    <= '0;
            r_err     <= '0;
        end else begin
            if (i_pop && (r_ret_cnt != {CNT_W{1'b1}}))
                r_ret_cnt <= w_ret_next;
            r_idle <= (i_drain && !i_pop) ? r_idle + DTMO_W'(1) : '0;
            if (i_init_tmo)
                r_err <= {ERR_W{1'b1}};
            else if (w_add_err && (r_err != {ERR_W{1'b1}}))
                r_err <= r_err + ERR_W'(1);
        end
    end

endmodule

// File: rtl/ddr3_host_traffic_gen.sv
// Host-side bring-up initiator: initializes the controller, writes a keyed
// pattern, reads it back and reports pass/fail.
module ddr3_host_traffic_gen
    import ddr3_pkg::*;
#(
    parameter int unsigned        NUM_WORDS     = 16,
    parameter logic [ADDR_W-1:0]  BASE_ADDR     = 25'h0000000,
    parameter logic [DATA_W-1:0]  SEED          = 16'hACE1,
    parameter logic [ITMO_W-1:0]  INIT_TIMEOUT  = 20'hFFFFF,
    parameter logic [DTMO_W-1:0]  DRAIN_TIMEOUT = 12'hFFF,
    parameter logic [FILL_W-1:0]  FILL_LIMIT    = 6'd56
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dout,
    input  logic [24:0] raddr,
    input  logic [5:0]  fillcount,
    input  logic        validout,
    input  logic        notfull,
    input  logic        ready,
    output logic        read,
    output logic [2:0]  cmd,
    output logic [1:0]  sz,
    output logic [2:0]  op,
    output logic [15:0] din,
    output logic [24:0] addr,
    output logic        initddr,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count
);

    tg_state_t         r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [ITMO_W-1:0] r_init_cnt;
    logic              r_initddr;
    logic              r_done;

    logic              w_in_write;
    logic              w_in_read;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              w_last_idx;
    logic              w_start_ok;
    logic              w_init_tmo;
    logic              w_all_returned;
    logic              w_drain_tmo;
    logic [ADDR_W-1:0] w_addr;
    logic [ERR_W-1:0]  w_err_count;
    cmd_t              w_cmd;

    assign w_in_write  = (r_state == ST_WRITE);
    assign w_in_read   = (r_state == ST_READ);
    assign w_wr_accept = w_in_write && notfull;
    assign w_rd_accept = w_in_read && notfull && (fillcount < FILL_LIMIT);
    assign w_last_idx  = (r_idx == IDX_W'(NUM_WORDS - 1));
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_init_tmo  = (r_state == ST_INIT) && !ready && (r_init_cnt == INIT_TIMEOUT);
    assign w_addr      = BASE_ADDR + ADDR_W'(r_idx);

    // Command, address and data are presented together, gated by the accept condition
    assign w_cmd = w_wr_accept ? CMD_SCW : (w_rd_accept ? CMD_SCR : CMD_NOP);
    assign cmd   = w_cmd;
    assign addr  = (w_in_write || w_in_read) ? w_addr : '0;
    assign din   = w_in_write ? expected_data(w_addr, SEED) : '0;
    assign sz    = 2'b00;
    assign op    = 3'b000;
    assign read  = validout && (w_in_read || (r_state == ST_DRAIN));

    assign initddr   = r_initddr;
    assign done      = r_done;
    assign pass      = r_done && (w_err_count == '0);
    assign err_count = w_err_count;

    ddr3_tg_checker #(
        .NUM_WORDS     (NUM_WORDS),
        .BASE_ADDR     (BASE_ADDR),
        .SEED          (SEED),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_checker (
        .clk              (clk),
        .reset            (reset),
        .i_clear          (w_start_ok),
        .i_pop            (read),
        .i_drain          (r_state == ST_DRAIN),
        .i_init_tmo       (w_init_tmo),
        .i_dout           (dout),
        .i_raddr          (raddr),
        .o_all_returned_c (w_all_returned),
        .o_drain_tmo_c    (w_drain_tmo),
        .o_err_count      (w_err_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_init_cnt <= '0;
            r_initddr  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // A controller that is already up is not re-initialized
                    if (start) begin
                        r_idx      <= '0;
                        r_init_cnt <= '0;
                        r_done     <= 1'b0;
                        if (ready) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state   <= ST_INIT;
                            r_initddr <= 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    if (ready) begin
                        r_state   <= ST_WRITE;
                        r_idx     <= '0;
                        r_initddr <= 1'b0;
                    end else if (w_init_tmo) begin
                        r_state   <= ST_DONE;
                        r_initddr <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + ITMO_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (w_wr_accept) begin
                        if (w_last_idx) begin
                            r_state <= ST_READ;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_READ: begin
                    if (w_rd_accept) begin
                        if (w_last_idx) begin
                            r_state <= ST_DRAIN;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_all_returned || w_drain_tmo) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_host_traffic_gen.sv
// Bench for ddr3_host_traffic_gen: behavioural controller with backpressure,
// read latency and fault injection; write/read scoreboards fed at stimulus time.
module tb_ddr3_host_traffic_gen;
    import ddr3_pkg::*;

    localparam int unsigned       NW       = 16;
    localparam logic [24:0]       BASE     = 25'h100;
    localparam logic [15:0]       SEED_V   = 16'hACE1;
    localparam logic [19:0]       INIT_TMO = 20'd200;
    localparam logic [5:0]        FILL_LIM = 6'd56;
    localparam int                LAT      = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dout = '0;
    logic [24:0] raddr = '0;
    logic [5:0]  fillcount = '0;
    logic        validout = 1'b0;
    logic        notfull = 1'b1;
    logic        ready = 1'b0;
    logic        read;
    logic [2:0]  cmd;
    logic [1:0]  sz;
    logic [2:0]  op;
    logic [15:0] din;
    logic [24:0] addr;
    logic        initddr;
    logic        done;
    logic        pass;
    logic [7:0]  err_count;

    ddr3_host_traffic_gen #(
        .NUM_WORDS     (NW),
        .BASE_ADDR     (BASE),
        .SEED          (SEED_V),
        .INIT_TIMEOUT  (INIT_TMO),
        .DRAIN_TIMEOUT (12'hFFF),
        .FILL_LIMIT    (FILL_LIM)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .dout(dout), .raddr(raddr),
        .fillcount(fillcount), .validout(validout), .notfull(notfull), .ready(ready),
        .read(read), .cmd(cmd), .sz(sz), .op(op), .din(din), .addr(addr),
        .initddr(initddr), .done(done), .pass(pass), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [24:0] a;
        logic [15:0] d;
    } ent_t;

    // Knobs written only by the stimulus process
    bit          clear_req = 1'b1;
    int          stall_after = -1;
    int          corrupt_cfg = 0;
    int          drop_cfg = 0;
    bit          force_fill = 1'b0;
    logic [5:0]  fill_val = '0;
    bit          ready_force_low = 1'b0;

    // Per-cycle observations handed from the monitor to the controller model
    bit          p_wr, p_rd, p_pop;
    logic [24:0] p_a;
    logic [15:0] p_d;

    // Controller model state
    logic [15:0] mem [logic [24:0]];
    ent_t        rq[$];
    ent_t        pipe[$];
    int          due[$];
    int          mcyc = 0;
    int          wr_acc = 0;
    int          rd_acc = 0;
    int          stall_left = 0;
    int          corrupt_left = 0;
    int          drop_left = 0;
    int          init_seen = 0;
    bit          ready_lat = 1'b0;

    always @(posedge clk) begin
        ent_t r;
        #1;
        if (clear_req) begin
            rq.delete(); pipe.delete(); due.delete();
            wr_acc = 0; rd_acc = 0; stall_left = 0;
            corrupt_left = corrupt_cfg; drop_left = drop_cfg;
        end else begin
            mcyc++;
            if (stall_left > 0) stall_left--;
            if (p_pop && rq.size() > 0) void'(rq.pop_front());
            if (p_wr) begin
                mem[p_a] = p_d;
                wr_acc++;
                if (wr_acc == stall_after) stall_left = 10;
            end
            if (p_rd) begin
                r.a = p_a;
                r.d = mem.exists(p_a) ? mem[p_a] : 16'h0000;
                pipe.push_back(r);
                due.push_back(mcyc + LAT);
                rd_acc++;
            end
            while (pipe.size() > 0 && due[0] <= mcyc) begin
                r = pipe.pop_front();
                void'(due.pop_front());
                if (drop_left > 0) begin
                    drop_left--;
                end else begin
                    if (corrupt_left > 0) begin
                        r.d[0] = ~r.d[0];
                        corrupt_left--;
                    end
                    rq.push_back(r);
                end
            end
            if (initddr === 1'b1 && init_seen < 20) init_seen++;
            if (init_seen >= 20) ready_lat = 1'b1;
        end
        ready     = ready_lat && !ready_force_low;
        notfull   = (stall_left == 0);
        fillcount = force_fill ? fill_val : ((rq.size() > 63) ? 6'd63 : 6'(rq.size()));
        validout  = (rq.size() > 0);
        dout      = validout ? rq[0].d : 16'h0000;
        raddr     = validout ? rq[0].a : 25'h0;
    end

    int   n_chk = 0;
    int   n_fail = 0;
    int   tcyc = 0;
    int   first_wr = -1;
    int   last_wr = -1;
    int   last_rd = -1;
    int   last_pop = -1;
    ent_t exp_wr[$];
    logic [24:0] exp_rd[$];

    // One cycle: advance to the negedge, check the handshake and score issued commands
    task automatic tick();
        ent_t ew;
        logic [24:0] ea;
        @(negedge clk);
        tcyc++;
        p_wr = 1'b0; p_rd = 1'b0; p_pop = 1'b0;
        if (reset !== 1'b1) begin
            if (notfull === 1'b0) begin
                n_chk++;
                if (cmd !== CMD_NOP) begin
                    n_fail++;
                    $display("FAIL cmd_while_notfull_low: cmd=%0d required=%0d", cmd, CMD_NOP);
                end
            end
            if (fillcount >= FILL_LIM) begin
                n_chk++;
                if (cmd === CMD_SCR) begin
                    n_fail++;
                    $display("FAIL scr_at_fill_limit: cmd=%0d fillcount=%0d required no SCR", cmd, fillcount);
                end
            end
            if (read === 1'b1) begin
                n_chk++;
                if (validout !== 1'b1) begin
                    n_fail++;
                    $display("FAIL read_when_empty: read=%b validout=%b required read=0", read, validout);
                end
                p_pop = 1'b1;
                last_pop = tcyc;
            end
            if (cmd === CMD_SCW) begin
                n_chk++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_write: addr=%h din=%h required no write", addr, din);
                end else begin
                    ew = exp_wr.pop_front();
                    if (addr !== ew.a || din !== ew.d) begin
                        n_fail++;
                        $display("FAIL write_sb: addr=%h din=%h required addr=%h din=%h", addr, din, ew.a, ew.d);
                    end
                end
                p_wr = 1'b1; p_a = addr; p_d = din;
                if (first_wr < 0) first_wr = tcyc;
                last_wr = tcyc;
            end
            if (cmd === CMD_SCR) begin
                n_chk++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_read: addr=%h required no read", addr);
                end else begin
                    ea = exp_rd.pop_front();
                    if (addr !== ea) begin
                        n_fail++;
                        $display("FAIL read_sb: addr=%h required %h", addr, ea);
                    end
                end
                p_rd = 1'b1; p_a = addr;
                last_rd = tcyc;
            end
        end
    endtask

    task automatic prep_run(input int corrupt, input int drop);
        ent_t e;
        corrupt_cfg = corrupt;
        drop_cfg    = drop;
        clear_req   = 1'b1;
        tick(); tick();
        clear_req   = 1'b0;
        exp_wr.delete(); exp_rd.delete();
        first_wr = -1; last_wr = -1; last_rd = -1; last_pop = -1;
        for (int i = 0; i < int'(NW); i++) begin
            e.a = BASE + 25'(i);
            e.d = e.a[15:0] ^ SEED_V;
            exp_wr.push_back(e);
            exp_rd.push_back(e.a);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: done=%b after %0d cycles required 1", done, n);
        end
    endtask

    task automatic check_clean_run(input string name, input logic [7:0] exp_err);
        n_chk++;
        if (done !== 1'b1 || err_count !== exp_err || pass !== (exp_err == 8'd0)) begin
            n_fail++;
            $display("FAIL %s_result: done=%b pass=%b err=%0d required done=1 pass=%b err=%0d",
                     name, done, pass, err_count, (exp_err == 8'd0), exp_err);
        end
        n_chk++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_cmds: writes_left=%0d reads_left=%0d required 0 0",
                     name, exp_wr.size(), exp_rd.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_chk++;
        if (cmd !== CMD_NOP || read !== 1'b0 || initddr !== 1'b0 || done !== 1'b0 ||
            pass !== 1'b0 || err_count !== 8'd0 || din !== 16'd0 || addr !== 25'd0) begin
            n_fail++;
            $display("FAIL %s: cmd=%0d read=%b initddr=%b done=%b pass=%b err=%0d din=%h addr=%h required all zero",
                     name, cmd, read, initddr, done, pass, err_count, din, addr);
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        check_reset_outputs("reset_values");
        n_chk++;
        if (sz !== 2'b00 || op !== 3'b000) begin
            n_fail++;
            $display("FAIL const_fields: sz=%b op=%b required 00 000", sz, op);
        end
        reset = 1'b0;
        tick();
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_full_bringup();
        int n;
        prep_run(0, 0);
        do_start();
        n_chk++;
        if (initddr !== 1'b1 || cmd !== CMD_NOP) begin
            n_fail++;
            $display("FAIL init_request: initddr=%b cmd=%0d required 1 %0d", initddr, cmd, CMD_NOP);
        end
        wait_done(2000, n);
        check_clean_run("bringup", 8'd0);
        n_chk++;
        if (tcyc - last_pop != 1) begin
            n_fail++;
            $display("FAIL done_latency: cycles_after_last_pop=%0d required 1", tcyc - last_pop);
        end
    endtask

    task automatic test_backpressure();
        int n;
        prep_run(0, 0);
        stall_after = 5;
        do_start();
        wait_done(2000, n);
        stall_after = -1;
        check_clean_run("backpressure", 8'd0);
        n_chk++;
        if (last_wr - first_wr != int'(NW) + 10 - 1) begin
            n_fail++;
            $display("FAIL write_span: span=%0d required %0d", last_wr - first_wr, int'(NW) + 9);
        end
    endtask

    task automatic test_corrupt();
        int n;
        prep_run(3, 0);
        do_start();
        wait_done(2000, n);
        check_clean_run("corrupt", 8'd3);
    endtask

    task automatic test_fill_pressure();
        int n;
        force_fill = 1'b1;
        fill_val   = 6'd56;
        prep_run(0, 0);
        do_start();
        n = 0;
        while (wr_acc < int'(NW) && n < 200) begin
            tick();
            n++;
        end
        for (int i = 0; i < 30; i++) tick();
        n_chk++;
        if (wr_acc != int'(NW) || rd_acc != 0) begin
            n_fail++;
            $display("FAIL fill_block: writes=%0d reads=%0d required %0d 0", wr_acc, rd_acc, NW);
        end
        fill_val = 6'd10;
        wait_done(2000, n);
        force_fill = 1'b0;
        check_clean_run("fill_resume", 8'd0);
    endtask

    task automatic test_drain_timeout();
        int n;
        prep_run(0, 1);
        do_start();
        wait_done(6000, n);
        check_clean_run("drain_timeout", 8'd1);
        n_chk++;
        if (tcyc - last_rd < 4095 || tcyc - last_rd > 4115) begin
            n_fail++;
            $display("FAIL drain_wait: cycles_after_last_scr=%0d required 4095..4115", tcyc - last_rd);
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        prep_run(0, 0);
        do_start();
        n = 0;
        while (wr_acc < 5 && n < 100) begin
            tick();
            n++;
        end
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        p_wr = 1'b0; p_rd = 1'b0; p_pop = 1'b0;
        clear_req = 1'b1;
        tick(); tick();
        reset = 1'b0;
        prep_run(0, 0);
        do_start();
        n_chk++;
        if (cmd !== CMD_SCW || initddr !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_direct_write: cmd=%0d initddr=%b required %0d 0", cmd, initddr, CMD_SCW);
        end
        wait_done(2000, n);
        check_clean_run("after_reset", 8'd0);
    endtask

    task automatic test_init_timeout();
        int n;
        ready_force_low = 1'b1;
        prep_run(0, 0);
        do_start();
        wait_done(600, n);
        n_chk++;
        if (n < 195 || n > 210) begin
            n_fail++;
            $display("FAIL init_timeout_latency: cycles=%0d required 195..210", n);
        end
        n_chk++;
        if (done !== 1'b1 || err_count !== 8'hFF || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL init_timeout_result: done=%b err=%h pass=%b required 1 ff 0", done, err_count, pass);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        p_wr = 1'b0; p_rd = 1'b0; p_pop = 1'b0;
        p_a = '0; p_d = '0;
        test_reset();
        test_full_bringup();
        test_backpressure();
        test_corrupt();
        test_fill_pressure();
        test_drain_timeout();
        test_reset_midrun();
        test_init_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
